// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage datapath and the multi-cycle mul/div unit.
// The datapath drives the request side; the unit drives busy/done/flags and the HI/LO view.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opA, opB, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit that owns the architectural HI/LO pair.
// Signed operations run on magnitudes; the sign correction is applied in the FIX cycle.
//
//   state | meaning
//   IDLE  | waiting for start; HI/LO write port active
//   CALC  | one shift-add / shift-subtract step per cycle, WIDTH steps
//   FIX   | sign-correct result, write HI/LO, pulse done on the next cycle
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     CLK,
    input logic     RST,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] m_reg;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
    logic             rem_ge;
    logic [2*WIDTH:0] acc_mul, acc_div;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CALC;
            CALC:    if (count == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand magnitudes are taken at accept so the iteration is always unsigned.
    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.opA[WIDTH-1];
        b_neg     = is_signed & bus.opB[WIDTH-1];
        a_mag     = a_neg ? -bus.opA : bus.opA;
        b_mag     = b_neg ? -bus.opB : bus.opB;
    end

    always_comb begin
        mul_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, m_reg} : '0);
        acc_mul = {1'b0, mul_sum, acc[WIDTH-1:1]};
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, m_reg});
        rem_sub = rem_ge ? (rem_sh - {1'b0, m_reg}) : rem_sh;
        acc_div = {rem_sub, acc[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        prod     = acc[2*WIDTH-1:0];
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count      <= '0;
            acc        <= '0;
            m_reg      <= '0;
            op_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz         <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        op_div <= bus.op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= bus.op[1] & (bus.opB == '0);
                        count  <= '0;
                        // mult: multiplier shifts out of the low half; div: dividend does
                        m_reg  <= bus.op[1] ? b_mag : a_mag;
                        acc    <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                    end
                end
                CALC: begin
                    acc   <= op_div ? acc_div : acc_mul;
                    count <= (count == LAST) ? '0 : count + 1'b1;
                end
                FIX: begin
                    done_r <= 1'b1;
                    if (op_div) begin
                        hi_r       <= rem_fix;
                        lo_r       <= dz ? '1 : quo_fix;
                        div_zero_r <= dz;
                    end else begin
                        hi_r       <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r       <= prod_fix[WIDTH-1:0];
                        div_zero_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO/div_zero come from a behavioural
// arithmetic model pushed at issue time and popped when done pulses.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] last_hi, last_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [63:0] p;
        int q, r;
        p = '0;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = a; e.hi = '0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    e.lo = q;
                    e.hi = r;
                end
            end
            default: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the done pulse has been checked.
    // mode 1: extra start pulses at +5/+20; mode 2: hi_we while busy; mode 3: hi_we with start.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode, input string tag);
        int lat, extra;
        logic [W-1:0] hi_before;
        exp_t e;
        bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b;
        if (mode == 3) begin bus.hi_we = 1'b1; bus.wdata = 32'h5555_AAAA; end
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        if (mode == 3) check({tag, "_wr_with_start"}, 64'(bus.hi), 64'h5555_AAAA);
        hi_before = bus.hi;
        lat = 0;
        while (lat < 100) begin
            if (mode == 1 && (lat == 5 || lat == 20)) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.opA = 32'd7; bus.opB = 32'd9;
            end
            if (mode == 2 && lat == 3) begin
                bus.hi_we = 1'b1; bus.wdata = 32'h1234;
            end
            @(negedge clk);
            lat++;
            bus.start = 1'b0; bus.hi_we = 1'b0;
            if (mode == 2 && lat == 4) check({tag, "_hi_we_busy"}, 64'(bus.hi), 64'(hi_before));
            if (bus.done) break;
        end
        // accept edge counts as the first of the 34 edges at WIDTH=32
        check({tag, "_latency"}, 64'(lat + 1), 64'(W + 2));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
            check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
            last_hi = e.hi;
            last_lo = e.lo;
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
        if (mode == 1) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            check({tag, "_no_extra_done"}, 64'(extra), 64'd0);
            check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        int dones;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0; bus.op = '0; bus.opA = '0; bus.opB = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        last_hi = '0; last_lo = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        run_op(2'b00, -32'sd7, 32'd3, 0, "mult_neg");
        run_op(2'b10, -32'sd7, 32'd2, 0, "div_neg");
        run_op(2'b11, 32'd100, 32'd0, 0, "divu_zero");
        run_op(2'b01, 32'd2, 32'd3, 0, "multu_clr_dz");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf_ignore");
        run_op(2'b10, 32'd7, -32'sd2, 0, "div_pos_neg");
        run_op(2'b10, -32'sd9, 32'd0, 0, "div_zero_neg");

        for (int i = 0; i < 4; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            run_op(rop, ra, rb, 0, "rand_op");
        end

        run_op(2'b00, 32'd5, -32'sd6, 2, "mult_hiwe_busy");

        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("idle_hi_we_hi", 64'(bus.hi), 64'h1234);
        check("idle_hi_we_lo_held", 64'(bus.lo), 64'(last_lo));
        bus.lo_we = 1'b1; bus.wdata = 32'hCAFE;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("idle_lo_we_lo", 64'(bus.lo), 64'hCAFE);
        check("idle_lo_we_hi_held", 64'(bus.hi), 64'h1234);

        run_op(2'b11, 32'd1000, 32'd7, 3, "divu_start_hiwe");

        // abort a MULT by reset mid-flight; its scoreboard entry is discarded
        bus.start = 1'b1; bus.op = 2'b00; bus.opA = -32'sd7; bus.opB = 32'd3;
        sb.push_back(model(2'b00, -32'sd7, 32'd3));
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check("abort_no_done", 64'(dones + int'(bus.done)), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        run_op(2'b01, 32'd123456, 32'd789, 0, "after_abort");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
